// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
//
// Turns the alarm comparator's time-match flag into a gated beep pattern.
// The pattern is 0.5 s of tone followed by 0.5 s of silence. The block
// supports stop, snooze (limited per alarm event), a ring timeout and a
// snooze duration, and drives the piezo pin and the status LEDs.
//
// Ports:
//   clk              system clock (CLK_HZ)
//   reset            synchronous, active-high
//   flag_alarm       time-match flag, high for the whole matching second
//   flag_alarm_armed 1 = alarm armed; dropping it silences everything
//   btn_stop         active-low pushbutton, asynchronous, already debounced
//   btn_snooze       active-low pushbutton, asynchronous, already debounced
//   buzzer           registered tone output to the piezo
//   ringing          1 while in RING
//   snoozing         1 while in SNOOZE
//   snooze_count     snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_ringer #(
   parameter int CLK_HZ         = 50000000,
   parameter int TONE_HZ        = 2000,
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_alarm,
   input  logic       flag_alarm_armed,
   input  logic       btn_stop,
   input  logic       btn_snooze,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_count
);

   localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
   localparam int SEC_MAX  = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
   localparam int PRE_W    = $clog2(CLK_HZ + 1);
   localparam int TONE_W   = $clog2(TONE_DIV + 1);
   localparam int SEC_W    = $clog2(SEC_MAX + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(CLK_HZ - 1);
   localparam logic [PRE_W-1:0]  PRE_HALF     = PRE_W'(CLK_HZ / 2);
   localparam logic [PRE_W-1:0]  PRE_ONE      = PRE_W'(1);
   localparam logic [TONE_W-1:0] TONE_LAST    = TONE_W'(TONE_DIV - 1);
   localparam logic [TONE_W-1:0] TONE_ONE     = TONE_W'(1);
   localparam logic [SEC_W-1:0]  RING_LAST    = SEC_W'(RING_TIMEOUT_S - 1);
   localparam logic [SEC_W-1:0]  SNOOZE_LAST  = SEC_W'(SNOOZE_S - 1);
   localparam logic [SEC_W-1:0]  SEC_ONE      = SEC_W'(1);
   localparam logic [1:0]        SNOOZE_LIMIT = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   state_t state, next_state;

   logic stop_ff0, stop_ff1, snz_ff0, snz_ff1;
   logic flag_alarm_d;
   logic [PRE_W-1:0]  prescaler, pre_nxt;
   logic [SEC_W-1:0]  sec_cnt, sec_nxt;
   logic [TONE_W-1:0] tone_cnt, tone_cnt_nxt;
   logic              tone_q, tone_q_nxt;
   logic [1:0]        snooze_count_nxt;

   logic stop_press, snz_press, trig, tick_1s, entry;

   // ff1 still holds the old (high) level while ff0 already sees the low level,
   // so each falling edge yields exactly one press cycle.
   assign stop_press = stop_ff1 & ~stop_ff0;
   assign snz_press  = snz_ff1 & ~snz_ff0;
   assign trig       = flag_alarm & ~flag_alarm_d;
   assign tick_1s    = (prescaler == PRE_LAST);

   // Next-state logic; within each state the checks run in priority order
   // disarm > stop > snooze > timeout.
   always_comb begin
      next_state       = state;
      snooze_count_nxt = snooze_count;
      case (state)
         IDLE: begin
            if (trig && flag_alarm_armed) begin
               next_state       = RING;
               snooze_count_nxt = 2'd0;
            end
         end
         RING: begin
            if (!flag_alarm_armed) begin
               next_state = IDLE;
            end else if (stop_press) begin
               next_state = IDLE;
            end else if (snz_press) begin
               if (snooze_count < SNOOZE_LIMIT) begin
                  next_state       = SNOOZE;
                  snooze_count_nxt = snooze_count + 2'd1;
               end else begin
                  next_state = IDLE;
               end
            end else if (tick_1s && (sec_cnt == RING_LAST)) begin
               next_state = IDLE;
            end
         end
         SNOOZE: begin
            if (!flag_alarm_armed) begin
               next_state = IDLE;
            end else if (stop_press) begin
               next_state = IDLE;
            end else if (tick_1s && (sec_cnt == SNOOZE_LAST)) begin
               next_state = RING;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Counter next values. Every state entry restarts the second timing so the
   // first second ends exactly CLK_HZ cycles after entry.
   always_comb begin
      entry = (next_state != state);

      pre_nxt = (entry || tick_1s) ? '0 : prescaler + PRE_ONE;

      sec_nxt = sec_cnt;
      if (entry) begin
         sec_nxt = '0;
      end else if (tick_1s && (state != IDLE)) begin
         sec_nxt = sec_cnt + SEC_ONE;
      end

      // Tone generator only runs while staying in RING; it restarts low on entry
      // and is forced low on the edge that leaves RING.
      tone_cnt_nxt = '0;
      tone_q_nxt   = 1'b0;
      if ((next_state == RING) && !entry) begin
         if (tone_cnt == TONE_LAST) begin
            tone_q_nxt = ~tone_q;
         end else begin
            tone_cnt_nxt = tone_cnt + TONE_ONE;
            tone_q_nxt   = tone_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         stop_ff0     <= 1'b1;
         stop_ff1     <= 1'b1;
         snz_ff0      <= 1'b1;
         snz_ff1      <= 1'b1;
         prescaler    <= '0;
         sec_cnt      <= '0;
         tone_cnt     <= '0;
         tone_q       <= 1'b0;
         snooze_count <= 2'd0;
         buzzer       <= 1'b0;
         ringing      <= 1'b0;
         snoozing     <= 1'b0;
      end else begin
         state        <= next_state;
         stop_ff0     <= btn_stop;
         stop_ff1     <= stop_ff0;
         snz_ff0      <= btn_snooze;
         snz_ff1      <= snz_ff0;
         prescaler    <= pre_nxt;
         sec_cnt      <= sec_nxt;
         tone_cnt     <= tone_cnt_nxt;
         tone_q       <= tone_q_nxt;
         snooze_count <= snooze_count_nxt;
         // Outputs are decoded from the next state so they change on the same
         // edge as the state register.
         buzzer       <= tone_q_nxt & (pre_nxt < PRE_HALF);
         ringing      <= (next_state == RING);
         snoozing     <= (next_state == SNOOZE);
      end
   end

   // The edge flop keeps sampling during reset, so a flag that is already high
   // when reset releases is not mistaken for a new rising edge.
   always_ff @(posedge clk) begin
      flag_alarm_d <= flag_alarm;
   end

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

   localparam int CLK_HZ   = 100;
   localparam int TONE_HZ  = 10;
   localparam int TONE_DIV = 5;
   localparam int RING_S   = 4;
   localparam int SNOOZE_S = 3;
   localparam int MAX_SNZ  = 2;

   logic       clk = 1'b0;
   logic       reset, flag_alarm, flag_alarm_armed, btn_stop, btn_snooze;
   logic       buzzer, ringing, snoozing;
   logic [1:0] snooze_count;

   alarm_ringer #(
      .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_TIMEOUT_S(RING_S),
      .SNOOZE_S(SNOOZE_S), .MAX_SNOOZE(MAX_SNZ)
   ) dut (
      .clk(clk), .reset(reset), .flag_alarm(flag_alarm),
      .flag_alarm_armed(flag_alarm_armed), .btn_stop(btn_stop),
      .btn_snooze(btn_snooze), .buzzer(buzzer), .ringing(ringing),
      .snoozing(snoozing), .snooze_count(snooze_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expected {ringing, snoozing, snooze_count, buzzer} per cycle.
   typedef struct {
      int         cyc;
      string      name;
      logic [4:0] exp;
   } sb_t;
   sb_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   sb_t        e_cur;
   logic [4:0] act;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e_cur = sb.pop_front();
         act = {ringing, snoozing, snooze_count, buzzer};
         n_checks++;
         if (act !== e_cur.exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: ring/snz/cnt/buz got %b required %b",
                     e_cur.name, cyc, act, e_cur.exp);
         end
      end
   end

   function automatic void expect_at(int c, string nm, logic r, logic s,
                                     logic [1:0] n, logic b);
      sb_t x;
      x.cyc  = c;
      x.name = nm;
      x.exp  = {r, s, n, b};
      sb.push_back(x);
   endfunction

   // Vector table: inputs held for 'hold' cycles, outputs checked at the end.
   typedef struct {
      string      name;
      logic       rst, armed, flag, stop_n, snz_n;
      int         hold;
      logic       ring, snz;
      logic [1:0] cnt;
      logic       buz;
   } vec_t;
   vec_t vt[$];

   function automatic void add(string nm, logic rst, logic armed, logic flag,
                               logic stop_n, logic snz_n, int hold,
                               logic ring, logic snz, logic [1:0] cnt, logic buz);
      vec_t v;
      v.name = nm; v.rst = rst; v.armed = armed; v.flag = flag;
      v.stop_n = stop_n; v.snz_n = snz_n; v.hold = hold;
      v.ring = ring; v.snz = snz; v.cnt = cnt; v.buz = buz;
      vt.push_back(v);
   endfunction

   task automatic apply_row(input vec_t v);
      reset            = v.rst;
      flag_alarm_armed = v.armed;
      flag_alarm       = v.flag;
      btn_stop         = v.stop_n;
      btn_snooze       = v.snz_n;
      expect_at(cyc + v.hold, v.name, v.ring, v.snz, v.cnt, v.buz);
      repeat (v.hold) @(negedge clk);
   endtask

   // Expected buzzer k cycles after RING entry: tone period 2*TONE_DIV,
   // gated by the first half of every second.
   function automatic logic beep(int k);
      return (((k / TONE_DIV) % 2) == 1) && ((k % CLK_HZ) < (CLK_HZ / 2));
   endfunction

   task automatic ring_pattern();
      int e;
      flag_alarm = 1'b1;
      e = cyc + 1;
      for (int k = 0; k < 130; k++) expect_at(e + k, "t1_pattern", 1'b1, 1'b0, 2'd0, beep(k));
      expect_at(e + 399, "t1_last_ring", 1'b1, 1'b0, 2'd0, beep(399));
      expect_at(e + 400, "t1_timeout", 1'b0, 1'b0, 2'd0, 1'b0);
      repeat (100) @(negedge clk);
      flag_alarm = 1'b0;
      repeat (301) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its end, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; flag_alarm = 1'b0; flag_alarm_armed = 1'b0;
      btn_stop = 1'b1; btn_snooze = 1'b1;

      //   name            rst arm flg stp snz hold   ring snz cnt buz
      add("reset_state",    1, 0, 0, 1, 1,   3,    0, 0, 2'd0, 0);
      add("arm_idle",       0, 1, 0, 1, 1,   2,    0, 0, 2'd0, 0);
      // snooze sequence up to the limit
      add("t2_trig",        0, 1, 1, 1, 1,   1,    1, 0, 2'd0, 0);
      add("t2_snz1",        0, 1, 1, 1, 0,   2,    0, 1, 2'd1, 0);
      add("t2_snz1_held",   0, 1, 0, 1, 0,   8,    0, 1, 2'd1, 0);
      add("t2_snz1_end",    0, 1, 0, 1, 1, 291,    0, 1, 2'd1, 0);
      add("t2_rering1",     0, 1, 0, 1, 1,   1,    1, 0, 2'd1, 0);
      add("t2_snz2",        0, 1, 0, 1, 0,   2,    0, 1, 2'd2, 0);
      add("t2_rering2",     0, 1, 0, 1, 1, 300,    1, 0, 2'd2, 0);
      add("t2_snz3_stop",   0, 1, 0, 1, 0,   2,    0, 0, 2'd2, 0);
      add("t2_idle_held",   0, 1, 0, 1, 1,   3,    0, 0, 2'd2, 0);
      // stop and snooze together
      add("t3_trig",        0, 1, 1, 1, 1,   1,    1, 0, 2'd0, 0);
      add("t3_snz",         0, 1, 1, 1, 0,   2,    0, 1, 2'd1, 0);
      add("t3_rering",      0, 1, 0, 1, 1, 300,    1, 0, 2'd1, 0);
      add("t3_both_sync",   0, 1, 0, 0, 0,   1,    1, 0, 2'd1, 0);
      add("t3_both_act",    0, 1, 0, 0, 0,   1,    0, 0, 2'd1, 0);
      add("t3_release",     0, 1, 0, 1, 1,   2,    0, 0, 2'd1, 0);
      // disarm while snoozing, flag edge while snoozing
      add("t4_trig",        0, 1, 1, 1, 1,   1,    1, 0, 2'd0, 0);
      add("t4_snz",         0, 1, 1, 1, 0,   2,    0, 1, 2'd1, 0);
      add("t4_snoozing",    0, 1, 0, 1, 1,   5,    0, 1, 2'd1, 0);
      add("t4_flag_ignored",0, 1, 1, 1, 1,   3,    0, 1, 2'd1, 0);
      add("t4_disarm",      0, 0, 1, 1, 1,   1,    0, 0, 2'd1, 0);
      // disarmed flag pulses
      add("t5_flag_low",    0, 0, 0, 1, 1,   2,    0, 0, 2'd1, 0);
      add("t5_flag_pulse",  0, 0, 1, 1, 1,   3,    0, 0, 2'd1, 0);
      add("t5_flag_fall",   0, 0, 0, 1, 1,   2,    0, 0, 2'd1, 0);
      // reset mid-ring with flag still high
      add("t6_arm",         0, 1, 0, 1, 1,   2,    0, 0, 2'd1, 0);
      add("t6_trig",        0, 1, 1, 1, 1,   1,    1, 0, 2'd0, 0);
      add("t6_beeping",     0, 1, 1, 1, 1,   6,    1, 0, 2'd0, 1);
      add("t6_reset",       1, 1, 1, 1, 1,   1,    0, 0, 2'd0, 0);
      add("t6_no_retrig",   0, 1, 1, 1, 1,   5,    0, 0, 2'd0, 0);
      add("t6_flag_fall",   0, 1, 0, 1, 1,   2,    0, 0, 2'd0, 0);
      add("t6_retrig",      0, 1, 1, 1, 1,   1,    1, 0, 2'd0, 0);
      // stop while the buzzer is high silences it on the leaving edge
      add("stop_beeping",   0, 1, 1, 1, 1,   6,    1, 0, 2'd0, 1);
      add("stop_sync",      0, 1, 1, 0, 1,   1,    1, 0, 2'd0, 1);
      add("stop_act",       0, 1, 1, 0, 1,   1,    0, 0, 2'd0, 0);
      add("stop_release",   0, 1, 0, 1, 1,   2,    0, 0, 2'd0, 0);

      @(negedge clk);
      for (int i = 0; i < 2; i++) apply_row(vt[i]);
      ring_pattern();
      for (int i = 2; i < vt.size(); i++) apply_row(vt[i]);

      repeat (2) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
